// File: rtl/mem_arbiter.sv
// mem_arbiter: three-port arbiter (two instruction-cache ports and one data
// port) in front of a single slow memory with a fetch-complete handshake.
// Each request is granted, issued with a one-cycle strobe, then
// acknowledged. Reads that see no fetch-complete within TIMEOUT cycles are
// abandoned with err set.
// Optional build macro DATA_PRIORITY_EN: the data port (req[2]) always wins
// in IDLE, and round-robin applies only between the two icache ports.

module mem_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int WIDTH   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       req,
  input  logic [2:0]       rnotw,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] addr2,
  input  logic [WIDTH-1:0] wdata2,
  output logic [2:0]       ack,
  output logic [WIDTH-1:0] rdata,
  output logic             err,
  output logic [2:0]       gnt,
  output logic             busy,
  output logic             m_strobe,
  output logic             m_rnotw,
  output logic [WIDTH-1:0] m_addr,
  output logic [WIDTH-1:0] m_wdata,
  input  logic             m_mfc,
  input  logic [WIDTH-1:0] m_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t          state, next_state;
  logic [1:0]      rr_ptr;
  logic [1:0]      nxt_ptr;
  logic [1:0]      win;
  logic [WIDTH-1:0] sel_addr;
  logic            sel_rnotw;
  logic [2:0]      eff_rnotw;
  logic [CW-1:0]   cnt;
  logic            timed_out;

  // icache ports are read-only, so their direction bits are forced to read
  assign eff_rnotw = rnotw | 3'b011;
  assign timed_out = (cnt == TO_LAST);
  assign busy      = (state != IDLE);

  // Pick the winning requester and the pointer value that follows its grant
  always_comb begin
    win = 2'd0;
    nxt_ptr = rr_ptr;
`ifdef DATA_PRIORITY_EN
    if (req[2])
      win = 2'd2;
    else if (rr_ptr == 2'd1)
      win = req[1] ? 2'd1 : 2'd0;
    else
      win = req[0] ? 2'd0 : 2'd1;
    case (win)
      2'd0:    nxt_ptr = 2'd1;
      2'd1:    nxt_ptr = 2'd0;
      default: nxt_ptr = rr_ptr;
    endcase
`else
    case (rr_ptr)
      2'd1:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd2:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
    case (win)
      2'd0:    nxt_ptr = 2'd1;
      2'd1:    nxt_ptr = 2'd2;
      default: nxt_ptr = 2'd0;
    endcase
`endif
  end

  // Route the winner's address and direction to the latch inputs
  always_comb begin
    sel_addr = addr0;
    sel_rnotw = eff_rnotw[0];
    case (win)
      2'd1: begin
        sel_addr = addr1;
        sel_rnotw = eff_rnotw[1];
      end
      2'd2: begin
        sel_addr = addr2;
        sel_rnotw = eff_rnotw[2];
      end
      default: begin
        sel_addr = addr0;
        sel_rnotw = eff_rnotw[0];
      end
    endcase
  end

  // Next-state logic: req is only looked at in IDLE, m_mfc only in WAIT
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|req) next_state = ISSUE;
      ISSUE:   next_state = m_rnotw ? WAIT : ACK;
      WAIT:    if (m_mfc || timed_out) next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Datapath registers: grant, memory bus, completion pulse and timeout count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt      <= 3'b000;
      ack      <= 3'b000;
      err      <= 1'b0;
      rdata    <= '0;
      m_strobe <= 1'b0;
      m_rnotw  <= 1'b1;
      m_addr   <= '0;
      m_wdata  <= '0;
      rr_ptr   <= 2'd0;
      cnt      <= '0;
    end else begin
      m_strobe <= 1'b0;
      ack      <= 3'b000;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt      <= 3'b001 << win;
            m_strobe <= 1'b1;
            m_addr   <= sel_addr;
            m_rnotw  <= sel_rnotw;
            m_wdata  <= wdata2;
            rr_ptr   <= nxt_ptr;
            cnt      <= '0;
            rdata    <= '0;
          end
        end
        ISSUE: begin
          if (!m_rnotw) ack <= gnt;
        end
        WAIT: begin
          if (m_mfc) begin
            ack   <= gnt;
            rdata <= m_rdata;
          end else if (timed_out) begin
            ack   <= gnt;
            err   <= 1'b1;
            rdata <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ACK: begin
          gnt   <= 3'b000;
          rdata <= '0;
          cnt   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized run against a transaction-level model of the arbiter.
// Latency counts are falling edges after the one where req is presented.
`timescale 1ns/1ps

module tb_mem_arbiter;

  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [2:0]       req = '0, rnotw = '0;
  logic [WIDTH-1:0] addr0 = '0, addr1 = '0, addr2 = '0, wdata2 = '0;
  logic [2:0]       ack, gnt;
  logic [WIDTH-1:0] rdata, m_addr, m_wdata, m_rdata;
  logic             err, busy, m_strobe, m_rnotw, m_mfc;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.TIMEOUT(TIMEOUT), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .req(req), .rnotw(rnotw),
    .addr0(addr0), .addr1(addr1), .addr2(addr2), .wdata2(wdata2),
    .ack(ack), .rdata(rdata), .err(err), .gnt(gnt), .busy(busy),
    .m_strobe(m_strobe), .m_rnotw(m_rnotw), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_mfc(m_mfc), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Slow memory: m_mfc rises memDelay edges after the strobe is seen
  logic [WIDTH-1:0] mem [0:255];
  logic [WIDTH-1:0] golden [0:255];
  int               memDelay = 4;
  bit               memStuck = 1'b0;
  bit               loaded = 1'b0;
  logic             memMfc = 1'b0, staleMfc = 1'b0;
  logic [WIDTH-1:0] memRdata = '0, staleData = '0;
  longint           edgeCount = 0, fireAt = 0;
  bit               armed = 1'b0;
  logic [7:0]       pendAddr = '0;

  assign m_mfc   = memMfc | staleMfc;
  assign m_rdata = staleMfc ? staleData : memRdata;

  function automatic logic [WIDTH-1:0] initVal(input int a);
    if (a == 'h10) return 16'h1234;
    if (a == 'h30) return 16'h5A5A;
    return WIDTH'((a * 'h0101) ^ 'h00F0);
  endfunction

  always @(posedge clk) begin
    edgeCount <= edgeCount + 1;
    memMfc <= 1'b0;
    if (reset) begin
      armed <= 1'b0;
      if (!loaded) begin
        for (int i = 0; i < 256; i++) mem[i] <= initVal(i);
        loaded <= 1'b1;
      end
    end else begin
      if (armed && edgeCount == fireAt) begin
        memMfc   <= 1'b1;
        memRdata <= mem[pendAddr];
        armed    <= 1'b0;
      end
      if (m_strobe && !m_rnotw) mem[m_addr[7:0]] <= m_wdata;
      if (m_strobe && m_rnotw && !memStuck) begin
        armed    <= 1'b1;
        fireAt   <= edgeCount + longint'(memDelay);
        pendAddr <= m_addr[7:0];
      end
    end
  end

  // Reference arbitration rules
  function automatic int rrPick(input logic [2:0] r, input int p);
`ifdef DATA_PRIORITY_EN
    if (r[2]) return 2;
    for (int k = 0; k < 2; k++) if (r[(p + k) % 2]) return (p + k) % 2;
`else
    for (int k = 0; k < 3; k++) if (r[(p + k) % 3]) return (p + k) % 3;
`endif
    return 0;
  endfunction

  function automatic int nextPtr(input int w, input int p);
`ifdef DATA_PRIORITY_EN
    return (w == 2) ? p : (w == 0 ? 1 : 0);
`else
    return (w + p * 0 + 1) % 3;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ack"}, ack, 0);
    checkOutput({tag, "_err"}, err, 0);
    checkOutput({tag, "_gnt"}, gnt, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_strobe"}, m_strobe, 0);
    checkOutput({tag, "_mrnotw"}, m_rnotw, 1);
    checkOutput({tag, "_rdata"}, rdata, 0);
    checkOutput({tag, "_maddr"}, m_addr, 0);
    checkOutput({tag, "_mwdata"}, m_wdata, 0);
  endtask

  int tbPtr = 0;

  task automatic doReset();
    req = '0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    reset = 1'b0;
    tbPtr = 0;
  endtask

  typedef struct {
    string            name;
    int               port;
    bit               isRead;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    int               delay;
    bit               stuck;
    bit               pulse;
    logic [2:0]       expAck;
    logic [WIDTH-1:0] expRdata;
    bit               expErr;
    int               expLat;
  } vec_t;

  vec_t vecs[$];

  // Present one single-requester transaction and check it end to end
  task automatic applyStimulus(input vec_t v);
    int lat;
    bit got;
    bit effRead;
    effRead = (v.port < 2) ? 1'b1 : v.isRead;
    @(negedge clk);
    memDelay = v.delay;
    memStuck = v.stuck;
    rnotw = 3'b000;
    rnotw[v.port] = v.isRead;
    addr0 = (v.port == 0) ? v.addr : 16'hFFF0;
    addr1 = (v.port == 1) ? v.addr : 16'hFFF1;
    addr2 = (v.port == 2) ? v.addr : 16'hFFF2;
    wdata2 = v.wdata;
    req = 3'b000;
    req[v.port] = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < TIMEOUT + 10) begin
      @(negedge clk);
      lat++;
      if (v.pulse) req = 3'b000;
      checkOutput({v.name, "_strobe"}, m_strobe, lat == 1);
      if (lat == 1) begin
        checkOutput({v.name, "_maddr"}, m_addr, v.addr);
        checkOutput({v.name, "_mrnotw"}, m_rnotw, effRead);
        if (!effRead) checkOutput({v.name, "_mwdata"}, m_wdata, v.wdata);
      end
      if (ack != 3'b000) got = 1'b1;
    end
    checkOutput({v.name, "_latency"}, lat, v.expLat);
    checkOutput({v.name, "_ack"}, ack, v.expAck);
    checkOutput({v.name, "_gnt"}, gnt, v.expAck);
    checkOutput({v.name, "_err"}, err, v.expErr);
    if (effRead) checkOutput({v.name, "_rdata"}, rdata, v.expRdata);
    else golden[v.addr[7:0]] = v.wdata;
    req = 3'b000;
    @(negedge clk);
    checkOutput({v.name, "_ackdrop"}, ack, 0);
    checkOutput({v.name, "_idlebusy"}, busy, 0);
    checkOutput({v.name, "_idlegnt"}, gnt, 0);
  endtask

  // Random-phase state
  bit               active[3];
  bit               isRd[3];
  logic [WIDTH-1:0] rAddr[3];
  logic [WIDTH-1:0] rData;
  bit               pending, justAcked, effRead, expErrR;
  int               win, age, expLat;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int expWin;
    bit got;
    logic [2:0] rrBits;

    for (int i = 0; i < 256; i++) golden[i] = initVal(i);
    #1 reset = 1'b1;
    doReset();

    // Directed single-requester vectors
    vecs.push_back('{"ic0_rd",       0, 1'b1, 16'h0010, 16'h0000, 4, 1'b0, 1'b0, 3'b001, 16'h1234, 1'b0, 7});
    vecs.push_back('{"data_wr",      2, 1'b0, 16'h0020, 16'hBEEF, 4, 1'b0, 1'b0, 3'b100, 16'h0000, 1'b0, 2});
    vecs.push_back('{"data_rd",      2, 1'b1, 16'h0020, 16'h0000, 4, 1'b0, 1'b0, 3'b100, 16'hBEEF, 1'b0, 7});
    vecs.push_back('{"ic1_rd_d2",    1, 1'b1, 16'h0030, 16'h0000, 2, 1'b0, 1'b0, 3'b010, 16'h5A5A, 1'b0, 5});
    vecs.push_back('{"ic0_timeout",  0, 1'b1, 16'h0040, 16'h0000, 4, 1'b1, 1'b0, 3'b001, 16'h0000, 1'b1, TIMEOUT + 2});
    vecs.push_back('{"ic1_after_to", 1, 1'b1, 16'h0010, 16'h0000, 4, 1'b0, 1'b0, 3'b010, 16'h1234, 1'b0, 7});
    vecs.push_back('{"ic1_pulse",    1, 1'b1, 16'h0030, 16'h0000, 4, 1'b0, 1'b1, 3'b010, 16'h5A5A, 1'b0, 7});
    vecs.push_back('{"ic0_wr_as_rd", 0, 1'b0, 16'h0020, 16'h0BAD, 1, 1'b0, 1'b0, 3'b001, 16'hBEEF, 1'b0, 4});
    vecs.push_back('{"data_rd_d1",   2, 1'b1, 16'h0010, 16'h0000, 1, 1'b0, 1'b0, 3'b100, 16'h1234, 1'b0, 4});
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Reset in the middle of a WAIT, then a stale completion after release
    @(negedge clk);
    memStuck = 1'b1;
    rnotw = 3'b001;
    addr0 = 16'h0044;
    req = 3'b001;
    repeat (5) @(negedge clk);
    req = 3'b000;
    #2 reset = 1'b1;
    #1 checkResetOutputs("midwait");
    @(negedge clk);
    reset = 1'b0;
    memStuck = 1'b0;
    tbPtr = 0;
    staleData = 16'hDEAD;
    staleMfc = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (t == 1) staleMfc = 1'b0;
      checkOutput("stale_ack", ack, 0);
      checkOutput("stale_busy", busy, 0);
      checkOutput("stale_rdata", rdata, 0);
    end
    applyStimulus('{"ic1_post_rst", 1, 1'b1, 16'h0010, 16'h0000, 4, 1'b0, 1'b0, 3'b010, 16'h1234, 1'b0, 7});

    // All three requesters held: grant order follows the rotation rules
    doReset();
    memDelay = 1;
    memStuck = 1'b0;
    rnotw = 3'b011;
    addr0 = 16'h0050;
    addr1 = 16'h0051;
    addr2 = 16'h0052;
    wdata2 = 16'h7777;
    rrBits = 3'b111;
    req = rrBits;
    for (int n = 0; n < 5; n++) begin
      expWin = rrPick(rrBits, tbPtr);
      got = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
        @(negedge clk);
        if (ack != 3'b000) got = 1'b1;
      end
      checkOutput($sformatf("rr_order%0d", n), ack, 3'b001 << expWin);
      checkOutput($sformatf("rr_gnt%0d", n), gnt, 3'b001 << expWin);
      tbPtr = nextPtr(expWin, tbPtr);
      if (expWin == 2) golden[8'h52] = 16'h7777;
      if (n == 2) begin
        rrBits = 3'b011;
        req = rrBits;
      end
      @(negedge clk);
      checkOutput($sformatf("rr_nogrant%0d", n), gnt, 0);
    end
    req = 3'b000;

    // Randomized traffic against the transaction-level model
    doReset();
    for (int i = 0; i < 3; i++) begin
      active[i] = 1'b0;
      isRd[i] = 1'b1;
      rAddr[i] = '0;
    end
    rData = '0;
    pending = 1'b0;
    win = 0;
    age = 0;
    expLat = 0;
    expErrR = 1'b0;
    effRead = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      justAcked = 1'b0;
      if (pending) begin
        age++;
        checkOutput("rnd_busy", busy, 1);
        checkOutput("rnd_gnt", gnt, 3'b001 << win);
        checkOutput("rnd_strobe", m_strobe, age == 1);
        if (age == 1) begin
          checkOutput("rnd_maddr", m_addr, rAddr[win]);
          checkOutput("rnd_mrnotw", m_rnotw, effRead);
          if (!effRead) checkOutput("rnd_mwdata", m_wdata, rData);
        end
        if (ack != 3'b000 || age >= expLat) begin
          checkOutput("rnd_latency", age, expLat);
          checkOutput("rnd_ack", ack, 3'b001 << win);
          checkOutput("rnd_err", err, expErrR);
          if (effRead) checkOutput("rnd_rdata", rdata, expErrR ? '0 : golden[rAddr[win][7:0]]);
          else golden[rAddr[win][7:0]] = rData;
          active[win] = 1'b0;
          pending = 1'b0;
          justAcked = 1'b1;
        end
      end else begin
        checkOutput("rnd_idle_ack", ack, 0);
        checkOutput("rnd_idle_busy", busy, 0);
        checkOutput("rnd_idle_strobe", m_strobe, 0);
      end
      for (int i = 0; i < 3; i++) begin
        if (!active[i] && $urandom_range(0, 3) == 0) begin
          active[i] = 1'b1;
          isRd[i] = (i < 2) ? 1'b1 : 1'($urandom_range(0, 1));
          rAddr[i] = WIDTH'($urandom_range(0, 31));
          if (i == 2) rData = WIDTH'($urandom);
        end
      end
      req = {active[2], active[1], active[0]};
      if (justAcked && $urandom_range(0, 1) == 1) req[win] = 1'b1;
      rnotw = {isRd[2], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
      addr0 = rAddr[0];
      addr1 = rAddr[1];
      addr2 = rAddr[2];
      wdata2 = rData;
      if (!pending && !justAcked && req != 3'b000) begin
        win = rrPick(req, tbPtr);
        tbPtr = nextPtr(win, tbPtr);
        pending = 1'b1;
        age = 0;
        effRead = (win < 2) || isRd[2];
        if (!effRead) begin
          expLat = 2;
          expErrR = 1'b0;
        end else if ($urandom_range(0, 9) == 0) begin
          memStuck = 1'b1;
          expLat = TIMEOUT + 2;
          expErrR = 1'b1;
        end else begin
          memStuck = 1'b0;
          memDelay = $urandom_range(1, 6);
          expLat = memDelay + 3;
          expErrR = 1'b0;
        end
      end
    end
    req = 3'b000;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
